sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Registered, handshaked controller for one external asynchronous SRAM; successor to the combinational framebuffer pin driver.
- Serves one requester (video fetch or CPU arbiter) through a valid/ready request port and a response pulse.
- Generalised in address width, data width (byte lanes) and programmable wait states.
- All pin outputs come from flops, so there is no clock-gated strobe.

Parameters:
- ADDR_W, 16: SRAM address width.
- DATA_W, 16: data width; must be a multiple of 8 (elaboration error otherwise).
- WAIT_STATES, 1: extra ACCESS cycles beyond the first; legal range 0..15.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables, active-high.
- rsp_valid  out  1  one-cycle completion pulse (reads and writes).
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid=1 and held until the next read completes.
- CE  out  1  chip enable, active-low.
- OE  out  1  output enable, active-low.
- WR  out  1  write enable, active-low.
- BE_PINS  out  DATA_W/8  byte lane enables, active-low (UB/LB for 16-bit).
- ADDRESS_PINS  out  ADDR_W  registered address.
- DATA_OUT_PINS  out  DATA_W  registered write data.
- DATA_OE  out  1  tristate drive enable for the top-level pad, active-high.
- DATA_IN_PINS  in  DATA_W  SRAM read data.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; CE=OE=WR=1; BE_PINS all 1; DATA_OE=0; rsp_valid=0; rsp_rdata=0; ADDRESS_PINS=0; DATA_OUT_PINS=0; wait counter=0. Mid-access reset aborts immediately and drives the pins inactive in the same instant.
- req_ready = (state==IDLE). It is combinational from state only, with no dependency on req_valid.
- Accept edge: req_valid & req_ready. On that edge, latch addr, wdata, be and write into ADDRESS_PINS, DATA_OUT_PINS, a BE register and a write flag.
- States: IDLE -> SETUP -> ACCESS -> END -> IDLE.
  - SETUP: 1 cycle.
  - ACCESS: WAIT_STATES+1 cycles, counted by a down-counter loaded with WAIT_STATES on entry.
  - END: 1 cycle.
- CE=0 in SETUP and ACCESS; CE=1 in END. END is the bus turnaround and hold cycle.
- Read:
  - OE=0 in SETUP and ACCESS; DATA_OE=0 throughout.
  - DATA_IN_PINS are sampled into rsp_rdata on the edge leaving the last ACCESS cycle.
  - rsp_valid=1 in END.
- Write:
  - DATA_OE=1 from SETUP through END; WR=0 only in ACCESS cycles.
  - Address and data are therefore stable for one cycle before and one cycle after WR.
  - OE stays 1. rsp_rdata is unchanged. rsp_valid=1 in END.
- BE_PINS = ~be in SETUP and ACCESS; all 1 otherwise. A read asserts the lanes per be.
- be all zero: the access still runs through the full sequence. For a write, WR stays 1 (no-op). rsp_valid still pulses.
- Latency, accept edge to rsp_valid high: WAIT_STATES+3 cycles.
- Throughput: one access per WAIT_STATES+4 cycles. The next accept can occur in the IDLE cycle right after END.
- ADDRESS_PINS and DATA_OUT_PINS hold their last values in IDLE, to avoid needless pin toggling.
- Request inputs are ignored outside the accept edge. Changes while not ready have no effect.
- Wait counter width: 4 bits. WAIT_STATES=0 gives exactly one ACCESS cycle.

Decomposition:
- Shared package sram_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, END) with 2-bit encoding;
  - localparam WAIT_CNT_W=4;
  - a function bytes(DATA_W) = DATA_W/8.
- Single module; no sub-module needed. The wait counter is inline.

Test Plan:
- Reset mid-write: assert RST_N=0 during ACCESS of a write to 0x0010 -> WR=1, CE=1, DATA_OE=0, BE_PINS=2'b11 immediately. After release, state=IDLE and req_ready=1.
- Read (WAIT_STATES=1): accept read addr 0x1234, model drives 0xBEEF -> CE/OE low for 3 cycles, rsp_valid high exactly 4 cycles after accept, rsp_rdata=0xBEEF.
- Write (WAIT_STATES=1): addr 0x00FF, data 0xA55A, be=2'b11 -> WR low for exactly 2 cycles; ADDRESS_PINS=0x00FF and DATA_OUT_PINS=0xA55A stable from SETUP through END; DATA_OE high 4 cycles; rsp_valid at +4.
- Byte lane: write be=2'b10 data 0x12xx, then read back -> BE_PINS=2'b01 during the write; model upper byte=0x12, lower byte unchanged.
- Back-to-back with WAIT_STATES=0 and req_valid held high for 3 requests -> accepts spaced 4 cycles apart; req_ready low in SETUP, ACCESS and END; three rsp_valid pulses.
- be=0 write -> WR never low; rsp_valid still pulses; SRAM model contents unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM port controller.
package sram_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StEnd    = 2'd3
  } state_e;

  // Width of the ACCESS-phase down-counter; bounds WAIT_STATES to 0..15.
  localparam int unsigned WAIT_CNT_W = 4;

  // Number of byte lanes for a given data width.
  function automatic int unsigned bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// Registered valid/ready controller for one external asynchronous SRAM.
// Every access runs IDLE -> SETUP -> ACCESS (WAIT_STATES+1 cycles) -> END -> IDLE.
// All pin outputs are driven straight from flops, so no strobe is ever gated by the clock.
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [bytes(DATA_W)-1:0]  req_be,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      CE,
  output logic                      OE,
  output logic                      WR,
  output logic [bytes(DATA_W)-1:0]  BE_PINS,
  output logic [ADDR_W-1:0]         ADDRESS_PINS,
  output logic [DATA_W-1:0]         DATA_OUT_PINS,
  output logic                      DATA_OE,
  input  logic [DATA_W-1:0]         DATA_IN_PINS
);

  localparam int unsigned BeW = bytes(DATA_W);
  localparam logic [WAIT_CNT_W-1:0] WaitLoad = WAIT_CNT_W'(WAIT_STATES);

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("sram_port_ctrl: DATA_W must be a non-zero multiple of 8");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("sram_port_ctrl: WAIT_STATES must be in 0..15");
  end

  state_e                state_q;
  logic [BeW-1:0]        be_q;
  logic                  write_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;

  // Ready depends on state only, never on req_valid.
  assign req_ready = (state_q == StIdle);

  // Sequencer with registered pin outputs; each branch sets the pin levels of the state entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      CE            <= 1'b1;
      OE            <= 1'b1;
      WR            <= 1'b1;
      BE_PINS       <= '1;
      DATA_OE       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      ADDRESS_PINS  <= '0;
      DATA_OUT_PINS <= '0;
      be_q          <= '0;
      write_q       <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            ADDRESS_PINS  <= req_addr;
            DATA_OUT_PINS <= req_wdata;
            be_q          <= req_be;
            write_q       <= req_write;
            state_q       <= StSetup;
            CE            <= 1'b0;
            OE            <= req_write;
            WR            <= 1'b1;
            BE_PINS       <= ~req_be;
            DATA_OE       <= req_write;
          end
        end
        StSetup: begin
          state_q    <= StAccess;
          wait_cnt_q <= WaitLoad;
          // A write with no lanes enabled still runs the sequence but never strobes WR.
          WR         <= ~(write_q & (|be_q));
        end
        StAccess: begin
          if (wait_cnt_q == '0) begin
            state_q   <= StEnd;
            CE        <= 1'b1;
            OE        <= 1'b1;
            WR        <= 1'b1;
            BE_PINS   <= '1;
            rsp_valid <= 1'b1;
            if (!write_q) begin
              rsp_rdata <= DATA_IN_PINS;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        StEnd: begin
          // Write data stays driven through END as the hold/turnaround cycle.
          state_q <= StIdle;
          DATA_OE <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed self-checking bench for sram_port_ctrl with a behavioural async SRAM model.
module tb_sram_port_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WAIT_STATES=1.
  logic        a_valid, a_ready, a_write, a_rsp_valid;
  logic [15:0] a_addr, a_wdata, a_rsp_rdata, a_address, a_dout, a_din;
  logic [1:0]  a_be, a_be_pins;
  logic        a_ce, a_oe, a_wr, a_doe;

  // Instance B: WAIT_STATES=0.
  logic        b_valid, b_ready, b_write, b_rsp_valid;
  logic [15:0] b_addr, b_wdata, b_rsp_rdata, b_address, b_dout, b_din;
  logic [1:0]  b_be, b_be_pins;
  logic        b_ce, b_oe, b_wr, b_doe;

  logic [15:0] mem1 [0:65535];
  logic [15:0] mem0 [0:65535];

  sram_port_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) dut_a (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .CE(a_ce), .OE(a_oe), .WR(a_wr), .BE_PINS(a_be_pins),
    .ADDRESS_PINS(a_address), .DATA_OUT_PINS(a_dout), .DATA_OE(a_doe),
    .DATA_IN_PINS(a_din)
  );

  sram_port_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) dut_b (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .CE(b_ce), .OE(b_oe), .WR(b_wr), .BE_PINS(b_be_pins),
    .ADDRESS_PINS(b_address), .DATA_OUT_PINS(b_dout), .DATA_OE(b_doe),
    .DATA_IN_PINS(b_din)
  );

  // SRAM models: reads only drive real data when selected and output-enabled.
  assign a_din = (!a_ce && !a_oe) ? mem1[a_address] : 16'hDEAD;
  assign b_din = (!b_ce && !b_oe) ? mem0[b_address] : 16'hDEAD;

  always @(posedge clk) begin
    if (!a_ce && !a_wr) begin
      if (!a_be_pins[0]) mem1[a_address][7:0]  = a_dout[7:0];
      if (!a_be_pins[1]) mem1[a_address][15:8] = a_dout[15:8];
    end
    if (!b_ce && !b_wr) begin
      if (!b_be_pins[0]) mem0[b_address][7:0]  = b_dout[7:0];
      if (!b_be_pins[1]) mem0[b_address][15:8] = b_dout[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-access observations on instance A.
  int ce_lo, oe_lo, wr_lo, doe_hi, rsp_at, rsp_cnt, stable_bad, be_bad;

  // Issue one access on A, scramble the request inputs after accept, observe 7 cycles.
  task automatic access_a(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be);
    ce_lo = 0; oe_lo = 0; wr_lo = 0; doe_hi = 0;
    rsp_at = 0; rsp_cnt = 0; stable_bad = 0; be_bad = 0;
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata; a_be = be;
    @(posedge clk); #1;
    a_valid = 1'b0; a_write = ~wr; a_addr = 16'hFFFF; a_wdata = ~wdata; a_be = ~be;
    for (int k = 1; k <= 7; k++) begin
      if (!a_ce) ce_lo++;
      if (!a_oe) oe_lo++;
      if (!a_wr) wr_lo++;
      if (a_doe) doe_hi++;
      if (a_rsp_valid) begin
        rsp_cnt++;
        rsp_at = k;
      end
      if (k <= 4 && (a_address !== addr || (wr && a_dout !== wdata))) stable_bad++;
      if (!a_ce && a_be_pins !== ~be) be_bad++;
      if (a_ce && a_be_pins !== 2'b11) be_bad++;
      @(posedge clk); #1;
    end
  endtask

  int          acc_cyc [0:3];
  logic [15:0] rd [0:2];
  int          n_acc, nr, rcnt;

  initial begin
    a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    mem1[16'h1234] = 16'hBEEF;
    mem1[16'h00FF] = 16'h0000;
    mem1[16'h0042] = 16'h3456;
    mem0[16'h0100] = 16'h1111;
    mem0[16'h0101] = 16'h2222;
    mem0[16'h0102] = 16'h3333;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", a_ce, 1);
    chk("rst_oe", a_oe, 1);
    chk("rst_wr", a_wr, 1);
    chk("rst_be", a_be_pins, 2'b11);
    chk("rst_doe", a_doe, 0);
    chk("rst_rsp", {a_rsp_valid, a_rsp_rdata}, 0);
    chk("rst_pins", {a_address, a_dout}, 0);
    chk("rst_ready", a_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a write.
    a_valid = 1; a_write = 1; a_addr = 16'h0010; a_wdata = 16'h7777; a_be = 2'b11;
    @(posedge clk); #1;
    a_valid = 0;
    @(posedge clk); #1;
    chk("midrst_pre_wr", a_wr, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr", a_wr, 1);
    chk("midrst_ce", a_ce, 1);
    chk("midrst_doe", a_doe, 0);
    chk("midrst_be", a_be_pins, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", a_ready, 1);

    // Read 0x1234.
    chk("rd_ready", a_ready, 1);
    access_a(1'b0, 16'h1234, 16'h0000, 2'b11);
    chk("rd_ce_lo", ce_lo, 3);
    chk("rd_oe_lo", oe_lo, 3);
    chk("rd_wr_lo", wr_lo, 0);
    chk("rd_doe", doe_hi, 0);
    chk("rd_rsp_at", rsp_at, 4);
    chk("rd_rsp_cnt", rsp_cnt, 1);
    chk("rd_be", be_bad, 0);
    chk("rd_data", a_rsp_rdata, 16'hBEEF);

    // Write 0x00FF <= 0xA55A.
    access_a(1'b1, 16'h00FF, 16'hA55A, 2'b11);
    chk("wr_wr_lo", wr_lo, 2);
    chk("wr_oe_lo", oe_lo, 0);
    chk("wr_doe_hi", doe_hi, 4);
    chk("wr_rsp_at", rsp_at, 4);
    chk("wr_stable", stable_bad, 0);
    chk("wr_mem", mem1[16'h00FF], 16'hA55A);
    chk("wr_rdata_hold", a_rsp_rdata, 16'hBEEF);

    // Upper-lane write, then read back.
    access_a(1'b1, 16'h0042, 16'h12CD, 2'b10);
    chk("bl_be", be_bad, 0);
    chk("bl_wr_lo", wr_lo, 2);
    chk("bl_mem", mem1[16'h0042], 16'h1256);
    access_a(1'b0, 16'h0042, 16'h0000, 2'b11);
    chk("bl_rdback", a_rsp_rdata, 16'h1256);

    // Write with no lanes enabled.
    access_a(1'b1, 16'h0042, 16'hFFFF, 2'b00);
    chk("be0_wr_lo", wr_lo, 0);
    chk("be0_rsp_cnt", rsp_cnt, 1);
    chk("be0_mem", mem1[16'h0042], 16'h1256);

    // Back-to-back reads on B with req_valid held high.
    n_acc = 0; nr = 0; rcnt = 0;
    b_valid = 1; b_write = 0; b_be = 2'b11; b_addr = 16'h0100;
    for (int c = 0; c < 20; c++) begin
      if (b_valid && b_ready) begin
        if (n_acc < 4) acc_cyc[n_acc] = c;
        n_acc++;
      end else if (!b_ready) begin
        nr++;
      end
      @(posedge clk); #1;
      b_addr = 16'h0100 + 16'(n_acc);
      if (n_acc >= 3) b_valid = 0;
      if (b_rsp_valid) begin
        if (rcnt < 3) rd[rcnt] = b_rsp_rdata;
        rcnt++;
      end
    end
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_acc1", acc_cyc[1] - acc_cyc[0], 4);
    chk("b2b_acc2", acc_cyc[2] - acc_cyc[1], 4);
    chk("b2b_notready", nr, 9);
    chk("b2b_rsp_cnt", rcnt, 3);
    chk("b2b_rd0", rd[0], 16'h1111);
    chk("b2b_rd1", rd[1], 16'h2222);
    chk("b2b_rd2", rd[2], 16'h3333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
